// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-port AXI read-channel arbiter:
// FSM state encodings, requester port IDs, default burst-length width
// and the active level of the asynchronous reset.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic PORT_ICACHE   = 1'b0;
    localparam logic PORT_DCACHE   = 1'b1;

    localparam int   LEN_W_DEFAULT = 4;

    // rst is active-low: the design is held in reset while rst == RST_N_ENABLE
    localparam logic RST_N_ENABLE  = 1'b0;

    // The port that did not win last time; used for tie-breaking in round-robin mode
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_arb_pick.sv
// Winner select for the two cache-miss requesters.
// Optional feature macro: RR_ARB_EN
//   defined   -> round-robin on a tie (the port that did not win last time)
//   undefined -> fixed priority, dcache (port 1) beats icache (port 0)
module axi_rd_arbiter_arb_pick
    import axi_rd_arbiter_pkg::*;
(
    input  logic arvalid0,
    input  logic arvalid1,
    input  logic last_grant,
    output logic winner,
    output logic any_req
);

    // A lone requester always wins; only the tie case depends on the policy
    always_comb begin
        any_req = arvalid0 | arvalid1;
        winner  = PORT_ICACHE;
`ifdef RR_ARB_EN
        if (arvalid0 && arvalid1) begin
            winner = other_port(last_grant);
        end else if (arvalid1) begin
            winner = PORT_DCACHE;
        end
`else
        if (arvalid1) begin
            winner = PORT_DCACHE;
        end
`endif
    end

`ifndef RR_ARB_EN
    // Fixed priority ignores the grant history
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI read arbiter: shares one AR+R channel between the icache
// (port 0) and the dcache (port 1). One burst owns the channel at a time;
// the AR request is registered, R beats are steered to the owner only,
// and the channel is released after the rlast handshake.
// Optional feature macro: RR_ARB_EN (round-robin tie break, see arb_pick).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | channel free; any pending request is picked and latched
// ARB_ADDR | m_arvalid high with the latched address/len, await m_arready
// ARB_DATA | R beats routed to the granted port until the rlast handshake
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = LEN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [LEN_W-1:0]  s0_arlen,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic              s0_rvalid,
    output logic              s0_rlast,
    input  logic              s0_rready,

    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [LEN_W-1:0]  s1_arlen,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic              s1_rvalid,
    output logic              s1_rlast,
    input  logic              s1_rready,

    output logic [ADDR_W-1:0] m_araddr,
    output logic [LEN_W-1:0]  m_arlen,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rvalid,
    input  logic              m_rlast,
    output logic              m_rready,

    output logic              busy
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             grant;
    logic [LEN_W-1:0] beat_cnt;
    logic             last_grant;
    logic             winner;
    logic             any_req;
    logic             granted_rready;
    logic             r_hs;

    axi_rd_arbiter_arb_pick u_arb_pick (
        .arvalid0   (s0_arvalid),
        .arvalid1   (s1_arvalid),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign granted_rready = (grant == PORT_DCACHE) ? s1_rready : s0_rready;
    assign r_hs           = (state == ARB_DATA) & m_rvalid & granted_rready;
    assign busy           = (state != ARB_IDLE);

    // State register; an async reset drops any burst in flight without draining
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_N_ENABLE) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the combinational AR-ready pulses and R-channel steering
    always_comb begin
        state_nxt  = state;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rdata   = '0;
        s1_rdata   = '0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        s0_rlast   = 1'b0;
        s1_rlast   = 1'b0;
        m_rready   = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_nxt = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                s0_arready = m_arready & (grant == PORT_ICACHE);
                s1_arready = m_arready & (grant == PORT_DCACHE);
                if (m_arready) begin
                    state_nxt = ARB_DATA;
                end
            end
            ARB_DATA: begin
                s0_rdata = m_rdata;
                s1_rdata = m_rdata;
                m_rready = granted_rready;
                if (grant == PORT_DCACHE) begin
                    s1_rvalid = m_rvalid;
                    s1_rlast  = m_rlast;
                end else begin
                    s0_rvalid = m_rvalid;
                    s0_rlast  = m_rlast;
                end
                if (r_hs && m_rlast) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Latch the winner's request in IDLE and hold it stable until accepted; count R beats
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_N_ENABLE) begin
            grant     <= PORT_ICACHE;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arvalid <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        grant     <= winner;
                        m_araddr  <= (winner == PORT_DCACHE) ? s1_araddr : s0_araddr;
                        m_arlen   <= (winner == PORT_DCACHE) ? s1_arlen  : s0_arlen;
                        m_arvalid <= 1'b1;
                        beat_cnt  <= '0;
                    end
                end
                ARB_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                    end
                end
                ARB_DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    m_arvalid <= 1'b0;
                end
            endcase
        end
    end

`ifdef RR_ARB_EN
    // Grant history for the round-robin tie break, updated as the address is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_N_ENABLE) begin
            last_grant <= PORT_ICACHE;
        end else if (state == ARB_ADDR && m_arready) begin
            last_grant <= grant;
        end
    end
`else
    assign last_grant = PORT_ICACHE;
`endif

`ifndef SYNTHESIS
    // The slave's rlast must land exactly on beat m_arlen+1 of the burst
    a_rlast_len : assert property (@(posedge clk) disable iff (rst == RST_N_ENABLE)
        (r_hs && m_rlast) |-> (beat_cnt == m_arlen))
        else $error("axi_rd_arbiter: rlast with beat_cnt=%0d, m_arlen=%0d", beat_cnt, m_arlen);
`endif

endmodule
